// File: rtl/vblank_update_scheduler_pkg.sv
// Shared types and screen constants for the vertical-blanking update scheduler
// and the video blocks around it.
package vblank_update_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_COMMIT = 3'd4
    } sched_state_t;

    localparam int Y_W          = 10;
    localparam int SCR_V_ACTIVE = 480;
    localparam int SCR_V_TOTAL  = 525;
    localparam int SCR_H_ACTIVE = 640;

endpackage

// File: rtl/vblank_update_scheduler_vline_event_det.sv
// Detects the first cycle of vertical blanking (line V_ACTIVE) and the first
// cycle of a new frame (line 0) from the raw line counter.
module vline_event_det
    import vblank_update_scheduler_pkg::*;
#(
    parameter int V_ACTIVE = SCR_V_ACTIVE
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [Y_W-1:0] pixel_y,
    output logic           vb_start,
    output logic           vb_end
);

    logic [Y_W-1:0] y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) y_q <= '0;
        else       y_q <= pixel_y;
    end

    // Edge of the line value, so a line held for many cycles fires only once.
    assign vb_start = (pixel_y == Y_W'(V_ACTIVE)) && (y_q != Y_W'(V_ACTIVE));
    assign vb_end   = (pixel_y == '0) && (y_q != '0);

endmodule

// File: rtl/vblank_update_scheduler.sv
// Grants each game-logic update unit a start/done slot in fixed order during
// vertical blanking, then pulses commit so video_gen latches the new frame state.
module vblank_update_scheduler
    import vblank_update_scheduler_pkg::*;
#(
    parameter int N_UNITS  = 4,
    parameter int V_ACTIVE = SCR_V_ACTIVE,
    parameter int TIMEOUT  = 4096,
    parameter int FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [Y_W-1:0]     pixel_y,
    input  logic               enable,
    input  logic [N_UNITS-1:0] unit_en,
    input  logic [N_UNITS-1:0] upd_done,
    input  logic               clear_flags,
    output logic [N_UNITS-1:0] upd_start,
    output logic               busy,
    output logic               commit,
    output logic               overrun_flag,
    output logic [N_UNITS-1:0] timeout_flags,
    output logic [FRAME_W-1:0] frame_count,
    output sched_state_t       state_dbg
);

    localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;

    sched_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [TMR_W-1:0] timer;
    logic             vb_start;
    logic             vb_end;

    vline_event_det #(.V_ACTIVE(V_ACTIVE)) u_vline_event_det (
        .clk      (clk),
        .reset    (reset),
        .pixel_y  (pixel_y),
        .vb_start (vb_start),
        .vb_end   (vb_end)
    );

    assign idx_nxt   = idx + IDX_W'(1);
    assign state_dbg = state;

    // Handshake: upd_start[i] is a 1-cycle grant; the unit owns its slot until it
    // raises upd_done[i] (level or pulse, only sampled while unit i is in WAIT)
    // or the slot times out. upd_start is issued on entry to START, so the START
    // state decides WAIT vs NEXT from the pulse it is currently driving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            timer         <= '0;
            upd_start     <= '0;
            busy          <= 1'b0;
            commit        <= 1'b0;
            overrun_flag  <= 1'b0;
            timeout_flags <= '0;
            frame_count   <= '0;
        end else begin
            upd_start <= '0;
            commit    <= 1'b0;
            if (clear_flags) begin
                overrun_flag  <= 1'b0;
                timeout_flags <= '0;
            end
            // Active video returned before commit: drop the frame.
            if (vb_end && (state inside {ST_START, ST_WAIT, ST_NEXT})) begin
                state        <= ST_IDLE;
                busy         <= 1'b0;
                overrun_flag <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (vb_start && enable) begin
                            idx       <= '0;
                            state     <= ST_START;
                            busy      <= 1'b1;
                            upd_start <= N_UNITS'(unit_en[0]);
                        end
                    end
                    ST_START: begin
                        timer <= '0;
                        state <= upd_start[idx] ? ST_WAIT : ST_NEXT;
                    end
                    ST_WAIT: begin
                        if (timer != '1) timer <= timer + TMR_W'(1);
                        if (upd_done[idx]) begin
                            state <= ST_NEXT;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            timeout_flags[idx] <= 1'b1;
                            state              <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (idx == IDX_W'(N_UNITS - 1)) begin
                            state  <= ST_COMMIT;
                            commit <= 1'b1;
                        end else begin
                            idx       <= idx_nxt;
                            state     <= ST_START;
                            upd_start <= unit_en[idx_nxt] ? (N_UNITS'(1) << idx_nxt) : '0;
                        end
                    end
                    ST_COMMIT: begin
                        frame_count <= frame_count + FRAME_W'(1);
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
